// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: load-use detection plus a one-entry multdiv scoreboard
// that stalls only dependent instructions. It also carries a sticky multdiv
// timeout flag and a saturating stall counter for performance debug.
// All state changes on the falling edge of the pipeline clock.
module hazard_scoreboard #(
  parameter int REG_W          = 5,
  parameter int COMPARE_REGS   = 1,
  parameter int STRICT_MULTDIV = 0,
  parameter int TIMEOUT        = 64,
  parameter int CNT_W          = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [31:0]       fd_insn,
  input  logic [31:0]       dx_insn,
  input  logic [31:0]       writeback_insn,
  input  logic              multdiv_RDY,
  output logic              is_bypass_hazard,
  output logic              latch_ena,
  output logic              multdiv_busy,
  output logic [REG_W-1:0]  pending_rd,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  stall_count
);

  // The BUSY counter only needs to reach TIMEOUT-1.
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] LAST_CNT = TW'(TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_q, state_d;
  logic [REG_W-1:0]   pending_rd_q, pending_rd_d;
  logic               timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0]   stall_count_q, stall_count_d;
  logic               latch_ena_q, latch_ena_d;
  logic [TW-1:0]      busy_cnt_q, busy_cnt_d;

  logic               lw_hazard;
  logic               multdiv_hazard;

  // An instruction is mul or div when it is R-type with ALU op 00110/00111.
  function automatic logic is_multdiv(input logic [31:0] insn);
    is_multdiv = (insn[31:27] == 5'b00000) &&
                 ((insn[6:2] == 5'b00110) || (insn[6:2] == 5'b00111));
  endfunction

  // True when insn reads register r; register 0 never counts as a read.
  // rs is always a source, rt only for R-type, rd for branches/jr/sw.
  function automatic logic reads_reg(input logic [31:0] insn, input logic [REG_W-1:0] r);
    logic [4:0] op;
    op = insn[31:27];
    reads_reg = 1'b0;
    if (r != '0) begin
      if (REG_W'(insn[21:17]) == r) reads_reg = 1'b1;
      if ((op == 5'b00000) && (REG_W'(insn[16:12]) == r)) reads_reg = 1'b1;
      if (((op == 5'b00010) || (op == 5'b00100) || (op == 5'b00110) || (op == 5'b00111)) &&
          (REG_W'(insn[26:22]) == r)) reads_reg = 1'b1;
    end
  endfunction

  // State register: every flop updates on the falling edge, async active-low reset.
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      pending_rd_q  <= '0;
      timeout_err_q <= 1'b0;
      stall_count_q <= '0;
      latch_ena_q   <= 1'b1;
      busy_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      pending_rd_q  <= pending_rd_d;
      timeout_err_q <= timeout_err_d;
      stall_count_q <= stall_count_d;
      latch_ena_q   <= latch_ena_d;
      busy_cnt_q    <= busy_cnt_d;
    end
  end

  // Next-state logic: capture a new multdiv in IDLE, retire it on RDY or timeout.
  always_comb begin
    state_d       = state_q;
    pending_rd_d  = pending_rd_q;
    timeout_err_d = timeout_err_q;
    busy_cnt_d    = busy_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (is_multdiv(dx_insn)) begin
          state_d      = BUSY;
          pending_rd_d = REG_W'(dx_insn[26:22]);
          busy_cnt_d   = '0;
        end
      end
      BUSY: begin
        if (multdiv_RDY) begin
          state_d = IDLE;
        end else if (busy_cnt_q == LAST_CNT) begin
          state_d       = IDLE;
          timeout_err_d = 1'b1;
        end else begin
          busy_cnt_d = busy_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: combinational hazards so a same-cycle RDY releases the stall.
  always_comb begin
    multdiv_busy = (state_q == BUSY);
    if (COMPARE_REGS != 0) begin
      lw_hazard = (dx_insn[31:27] == 5'b01000) && (dx_insn[26:22] != 5'd0) &&
                  reads_reg(fd_insn, REG_W'(dx_insn[26:22]));
    end else begin
      lw_hazard = (dx_insn[31:27] == 5'b01000);
    end
    multdiv_hazard = multdiv_busy && !multdiv_RDY &&
                     ((STRICT_MULTDIV != 0) || reads_reg(fd_insn, pending_rd_q) ||
                      is_multdiv(fd_insn));
    is_bypass_hazard = reset_n && (lw_hazard || multdiv_hazard);
  end

  // Debug/writeback next values: M/W enable and the saturating stall counter.
  always_comb begin
    latch_ena_d   = !(is_multdiv(writeback_insn) && !multdiv_RDY);
    stall_count_d = stall_count_q;
    if (is_bypass_hazard && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  assign pending_rd  = pending_rd_q;
  assign timeout_err = timeout_err_q;
  assign stall_count = stall_count_q;
  assign latch_ena   = latch_ena_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard. Two instances share the same stimulus:
// A is the register-compare, dependency-only variant with a short timeout
// and a 2-bit stall counter; B is the legacy conservative variant.
module tb_hazard_scoreboard;

  logic        clock;
  logic        reset_n;
  logic [31:0] fd_insn, dx_insn, writeback_insn;
  logic        multdiv_RDY;

  logic        haz_a, le_a, busy_a, err_a;
  logic [4:0]  prd_a;
  logic [1:0]  cnt_a;
  logic        haz_b, le_b, busy_b, err_b;
  logic [4:0]  prd_b;
  logic [15:0] cnt_b;

  int testsRun = 0;
  int testsFailed = 0;

  hazard_scoreboard #(.REG_W(5), .COMPARE_REGS(1), .STRICT_MULTDIV(0), .TIMEOUT(4), .CNT_W(2)) dutA (
    .clock(clock), .reset_n(reset_n), .fd_insn(fd_insn), .dx_insn(dx_insn),
    .writeback_insn(writeback_insn), .multdiv_RDY(multdiv_RDY),
    .is_bypass_hazard(haz_a), .latch_ena(le_a), .multdiv_busy(busy_a),
    .pending_rd(prd_a), .timeout_err(err_a), .stall_count(cnt_a)
  );

  hazard_scoreboard #(.REG_W(5), .COMPARE_REGS(0), .STRICT_MULTDIV(1), .TIMEOUT(64), .CNT_W(16)) dutB (
    .clock(clock), .reset_n(reset_n), .fd_insn(fd_insn), .dx_insn(dx_insn),
    .writeback_insn(writeback_insn), .multdiv_RDY(multdiv_RDY),
    .is_bypass_hazard(haz_b), .latch_ena(le_b), .multdiv_busy(busy_b),
    .pending_rd(prd_b), .timeout_err(err_b), .stall_count(cnt_b)
  );

  // Falling edges land at 5, 15, 25...; stimulus is driven 1 after each rising edge.
  initial begin
    clock = 1'b1;
    forever #5 clock = ~clock;
  end

  typedef struct {
    string       name;
    logic [31:0] fd;
    logic [31:0] dx;
    logic        expA;
    logic        expB;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] aluop);
    rtype = {5'b00000, rd, rs, rt, 5'b00000, aluop, 2'b00};
  endfunction

  function automatic logic [31:0] itype(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [16:0] imm);
    itype = {op, rd, rs, imm};
  endfunction

  // Drive one cycle of inputs, then leave time for combinational outputs to settle.
  task automatic applyStimulus(input logic [31:0] f, input logic [31:0] d,
                               input logic [31:0] w, input logic r);
    @(posedge clock);
    #1;
    fd_insn        = f;
    dx_insn        = d;
    writeback_insn = w;
    multdiv_RDY    = r;
    #2;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] nop, mul7, div8, mul9, mul3, lw5, addDep7, addInd, wbMul;
    nop     = rtype(5'd0, 5'd0, 5'd0, 5'd0);
    mul7    = rtype(5'd7, 5'd1, 5'd2, 5'b00110);
    div8    = rtype(5'd8, 5'd3, 5'd4, 5'b00111);
    mul9    = rtype(5'd9, 5'd1, 5'd2, 5'b00110);
    mul3    = rtype(5'd3, 5'd1, 5'd2, 5'b00110);
    lw5     = itype(5'b01000, 5'd5, 5'd2, 17'd0);
    addDep7 = rtype(5'd1, 5'd7, 5'd2, 5'd0);
    addInd  = rtype(5'd1, 5'd2, 5'd3, 5'd0);
    wbMul   = rtype(5'd6, 5'd1, 5'd2, 5'b00110);

    vecs[0] = '{"lw_rs_match",    rtype(5'd1, 5'd5, 5'd2, 5'd0), lw5, 1'b1, 1'b1};
    vecs[1] = '{"lw_no_match",    rtype(5'd1, 5'd3, 5'd2, 5'd0), lw5, 1'b0, 1'b1};
    vecs[2] = '{"lw_r0",          rtype(5'd1, 5'd0, 5'd0, 5'd0),
                                  itype(5'b01000, 5'd0, 5'd2, 17'd0), 1'b0, 1'b1};
    vecs[3] = '{"lw_rt_match",    rtype(5'd1, 5'd2, 5'd5, 5'd0), lw5, 1'b1, 1'b1};
    vecs[4] = '{"lw_itype_rt",    itype(5'b00101, 5'd5, 5'd2, {5'd5, 12'd0}), lw5, 1'b0, 1'b1};
    vecs[5] = '{"lw_bne_rd",      itype(5'b00010, 5'd5, 5'd1, 17'd0), lw5, 1'b1, 1'b1};
    vecs[6] = '{"lw_sw_rd",       itype(5'b00111, 5'd5, 5'd1, 17'd0), lw5, 1'b1, 1'b1};
    vecs[7] = '{"add_not_lw",     rtype(5'd1, 5'd5, 5'd2, 5'd0), rtype(5'd5, 5'd1, 5'd2, 5'd0), 1'b0, 1'b0};
    vecs[8] = '{"lw_then_lw",     itype(5'b01000, 5'd1, 5'd5, 17'd0), lw5, 1'b1, 1'b1};
    vecs[9] = '{"nop_nop",        rtype(5'd1, 5'd5, 5'd2, 5'd0), nop, 1'b0, 1'b0};

    reset_n = 1'b0;
    fd_insn = nop; dx_insn = nop; writeback_insn = nop; multdiv_RDY = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    #1;
    checkOutput("rst_haz", haz_a, 0);
    checkOutput("rst_busy", busy_a, 0);
    checkOutput("rst_prd", prd_a, 0);
    checkOutput("rst_err", err_a, 0);
    checkOutput("rst_cnt", cnt_a, 0);
    checkOutput("rst_latch", le_a, 1);
    applyStimulus(nop, nop, nop, 1'b0);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].fd, vecs[i].dx, nop, 1'b0);
      checkOutput({vecs[i].name, "_A"}, haz_a, vecs[i].expA);
      checkOutput({vecs[i].name, "_B"}, haz_b, vecs[i].expB);
    end

    applyStimulus(nop, nop, nop, 1'b0);
    checkOutput("cnt_a_saturated", cnt_a, 3);
    checkOutput("cnt_b_count", cnt_b, 8);

    applyStimulus(nop, mul7, nop, 1'b0);
    checkOutput("mul_idle_haz", haz_a, 0);
    applyStimulus(addDep7, nop, nop, 1'b0);
    checkOutput("sb_busy", busy_a, 1);
    checkOutput("sb_prd7", prd_a, 7);
    checkOutput("sb_dep_haz_A", haz_a, 1);
    checkOutput("sb_dep_haz_B", haz_b, 1);
    applyStimulus(addInd, nop, nop, 1'b0);
    checkOutput("sb_ind_haz_A", haz_a, 0);
    checkOutput("sb_ind_haz_B", haz_b, 1);
    applyStimulus(addDep7, nop, nop, 1'b1);
    checkOutput("sb_rdy_haz_A", haz_a, 0);
    checkOutput("sb_rdy_haz_B", haz_b, 0);
    checkOutput("sb_rdy_busy", busy_a, 1);
    applyStimulus(nop, nop, nop, 1'b0);
    checkOutput("sb_idle_A", busy_a, 0);
    checkOutput("sb_idle_B", busy_b, 0);

    applyStimulus(nop, mul7, nop, 1'b0);
    applyStimulus(div8, nop, nop, 1'b0);
    checkOutput("b2b_fd_div_haz", haz_a, 1);
    applyStimulus(nop, div8, nop, 1'b1);
    checkOutput("b2b_rdy_haz", haz_a, 0);
    applyStimulus(nop, div8, nop, 1'b0);
    checkOutput("b2b_went_idle", busy_a, 0);
    checkOutput("b2b_prd_kept", prd_a, 7);
    applyStimulus(nop, mul9, nop, 1'b0);
    checkOutput("b2b_busy", busy_a, 1);
    checkOutput("b2b_prd8", prd_a, 8);
    applyStimulus(nop, nop, nop, 1'b1);
    checkOutput("b2b_no_recapture", prd_a, 8);
    applyStimulus(nop, nop, nop, 1'b0);
    checkOutput("b2b_done", busy_a, 0);

    applyStimulus(nop, mul3, nop, 1'b0);
    repeat (3) applyStimulus(nop, nop, nop, 1'b0);
    applyStimulus(nop, nop, nop, 1'b0);
    checkOutput("to_busy_before", busy_a, 1);
    checkOutput("to_err_before", err_a, 0);
    applyStimulus(nop, nop, nop, 1'b0);
    checkOutput("to_err_set", err_a, 1);
    checkOutput("to_busy_clr", busy_a, 0);
    checkOutput("to_B_still_busy", busy_b, 1);
    applyStimulus(nop, nop, nop, 1'b0);
    checkOutput("to_err_sticky", err_a, 1);

    applyStimulus(rtype(5'd1, 5'd5, 5'd2, 5'd0), lw5, nop, 1'b0);
    reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_haz_A", haz_a, 0);
    checkOutput("mid_rst_haz_B", haz_b, 0);
    checkOutput("mid_rst_busy_B", busy_b, 0);
    checkOutput("mid_rst_prd_B", prd_b, 0);
    checkOutput("mid_rst_err_A", err_a, 0);
    checkOutput("mid_rst_cnt_B", cnt_b, 0);
    checkOutput("mid_rst_latch", le_a, 1);
    @(posedge clock);
    #1 reset_n = 1'b1;

    applyStimulus(nop, nop, wbMul, 1'b0);
    checkOutput("le_before_edge", le_a, 1);
    applyStimulus(nop, nop, wbMul, 1'b0);
    checkOutput("le_low", le_a, 0);
    applyStimulus(nop, nop, wbMul, 1'b1);
    checkOutput("le_still_low", le_a, 0);
    applyStimulus(nop, nop, nop, 1'b0);
    checkOutput("le_high", le_a, 1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
